// File: rtl/channel_deinterleaver.sv
// Reassembles a serial 4-word channel stream into one parallel group per pixel, flagging groups whose in_last marker is misaligned.
// Optional error counter (err_count/err_clr) is built when DEINTLV_ERR_CNT_EN is defined.
module channel_deinterleaver #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_CHANNELS = 4,
   parameter int IDX_W        = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_ch0,
   output logic [DATA_WIDTH-1:0] out_ch1,
   output logic [DATA_WIDTH-1:0] out_ch2,
   output logic [DATA_WIDTH-1:0] out_ch3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  err_align
`ifdef DEINTLV_ERR_CNT_EN
   ,
   input  logic                  err_clr,
   output logic [15:0]           err_count
`endif
);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   asm_q [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]   asm_d [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]   out_q [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]   out_d [NUM_CHANNELS];
   logic                    outValid_q, outValid_d;
   logic                    errAlign_q, errAlign_d;

   logic                    accept;
   logic                    atLastIdx;
   logic                    outFree;

   assign in_ready  = (state_q == COLLECT);
   assign accept    = in_valid & in_ready;
   assign atLastIdx = (idx_q == LAST_IDX);
   assign outFree   = ~outValid_q | out_ready;

   // A completed group goes straight to the output bank when it is free; otherwise it parks in asm and HOLD stalls input.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      asm_d      = asm_q;
      out_d      = out_q;
      outValid_d = outValid_q;
      errAlign_d = 1'b0;

      if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
      end

      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (in_last && !atLastIdx) begin
                  errAlign_d = 1'b1;
                  idx_d      = '0;
               end else if (!atLastIdx) begin
                  asm_d[idx_q] = in_data;
                  idx_d        = idx_q + 1'b1;
               end else begin
                  errAlign_d      = ~in_last;
                  idx_d           = '0;
                  asm_d[LAST_IDX] = in_data;
                  if (outFree) begin
                     for (int i = 0; i < NUM_CHANNELS - 1; i++) begin
                        out_d[i] = asm_q[i];
                     end
                     out_d[NUM_CHANNELS-1] = in_data;
                     outValid_d            = 1'b1;
                  end else begin
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_d      = asm_q;
               outValid_d = 1'b1;
               state_d    = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= COLLECT;
         idx_q      <= '0;
         outValid_q <= 1'b0;
         errAlign_q <= 1'b0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            asm_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         outValid_q <= outValid_d;
         errAlign_q <= errAlign_d;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            asm_q[i] <= asm_d[i];
            out_q[i] <= out_d[i];
         end
      end
   end

   assign out_ch0   = out_q[0];
   assign out_ch1   = out_q[1];
   assign out_ch2   = out_q[2];
   assign out_ch3   = out_q[3];
   assign out_valid = outValid_q;
   assign err_align = errAlign_q;

`ifdef DEINTLV_ERR_CNT_EN
   logic [15:0] errCount_q, errCount_d;

   // Clear wins over a coincident increment; the count sticks at all-ones.
   always_comb begin
      errCount_d = errCount_q;
      if (err_clr) begin
         errCount_d = '0;
      end else if (errAlign_q && (errCount_q != 16'hFFFF)) begin
         errCount_d = errCount_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errCount_q <= '0;
      end else begin
         errCount_q <= errCount_d;
      end
   end

   assign err_count = errCount_q;
`endif

endmodule

// File: tb/tb_channel_deinterleaver.sv
// Scoreboard bench for channel_deinterleaver: a word-level model queues expected groups, a monitor pops them on each output transfer.
module tb_channel_deinterleaver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [15:0] out_ch0, out_ch1, out_ch2, out_ch3;
   logic        out_valid;
   logic        out_ready;
   logic        err_align;
`ifdef DEINTLV_ERR_CNT_EN
   logic        err_clr;
   logic [15:0] err_count;
`endif

   logic [63:0] outBus;
   logic [63:0] sb [$];
   int          popCycles [$];
   logic [15:0] modelAsm [4];
   int          modelIdx = 0;
   int          vectorCount = 0;
   int          missCount = 0;
   int          cycleCount = 0;
   int          seenErr = 0;
   int          expErr = 0;
   int          lastWait = 0;

   channel_deinterleaver #(
      .DATA_WIDTH(16),
      .NUM_CHANNELS(4),
      .IDX_W(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_last(in_last),
      .in_ready(in_ready),
      .out_ch0(out_ch0),
      .out_ch1(out_ch1),
      .out_ch2(out_ch2),
      .out_ch3(out_ch3),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .err_align(err_align)
`ifdef DEINTLV_ERR_CNT_EN
      ,
      .err_clr(err_clr),
      .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   assign outBus = {out_ch0, out_ch1, out_ch2, out_ch3};

   always @(posedge clk) cycleCount++;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", tag, actual, expected);
      end
   endtask

   // Output transfers are sampled mid-cycle, when out_valid/out_ready are settled for the coming edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("sbUnderflow", {63'd0, out_valid}, 64'd0);
         end else begin
            checkOutput("group", outBus, sb.pop_front());
         end
         popCycles.push_back(cycleCount);
      end
      if (rst_n && err_align) seenErr++;
   end

   task automatic modelAccept(input logic [15:0] d, input logic last);
      if (last && modelIdx != 3) begin
         expErr++;
         modelIdx = 0;
      end else begin
         modelAsm[modelIdx] = d;
         if (modelIdx == 3) begin
            sb.push_back({modelAsm[0], modelAsm[1], modelAsm[2], modelAsm[3]});
            if (!last) expErr++;
            modelIdx = 0;
         end else begin
            modelIdx++;
         end
      end
   endtask

   task automatic applyStimulus(input logic [15:0] d, input logic last);
      int waited = 0;
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      lastWait = waited;
      if (!in_ready) checkOutput("acceptTimeout", {63'd0, in_ready}, 64'd1);
      else modelAccept(d, last);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic doReset(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst_n    = 1'b0;
      sb.delete();
      modelIdx = 0;
      repeat (n) begin
         @(negedge clk);
         checkOutput("rstValid", {63'd0, out_valid}, 64'd0);
         checkOutput("rstData", outBus, 64'd0);
         checkOutput("rstErr", {63'd0, err_align}, 64'd0);
         checkOutput("rstReady", {63'd0, in_ready}, 64'd1);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int acceptCycle;
      int maxWait;
      int errBase;
      int w;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
`ifdef DEINTLV_ERR_CNT_EN
      err_clr   = 1'b0;
`endif
      rst_n     = 1'b0;
      #2;
      doReset(2);

      // Single group, one-cycle latency, valid for exactly one cycle
      applyStimulus(16'd10, 1'b0);
      applyStimulus(16'd20, 1'b0);
      applyStimulus(16'd30, 1'b0);
      applyStimulus(16'd40, 1'b1);
      acceptCycle = cycleCount;
      idle(3);
      checkOutput("t1Latency", 64'(popCycles[popCycles.size()-1]), 64'(acceptCycle));
      checkOutput("t1Drained", {63'd0, out_valid}, 64'd0);
      checkOutput("t1Err", 64'(seenErr), 64'(expErr));

      // Back-to-back groups at full rate
      maxWait = 0;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(16'(i), (i % 4) == 0);
         if (lastWait > maxWait) maxWait = lastWait;
      end
      idle(3);
      checkOutput("t2NoStall", 64'(maxWait), 64'd0);
      checkOutput("t2Spacing", 64'(popCycles[popCycles.size()-1] - popCycles[popCycles.size()-2]), 64'd4);

      // Backpressure: second group parks, input stalls, then both drain in order
      out_ready = 1'b0;
      applyStimulus(16'd100, 1'b0);
      applyStimulus(16'd200, 1'b0);
      applyStimulus(16'd300, 1'b0);
      applyStimulus(16'd400, 1'b1);
      applyStimulus(16'd5, 1'b0);
      applyStimulus(16'd6, 1'b0);
      applyStimulus(16'd7, 1'b0);
      applyStimulus(16'd8, 1'b1);
      @(negedge clk);
      checkOutput("t3ReadyDrop", {63'd0, in_ready}, 64'd0);
      repeat (4) begin
         @(negedge clk);
         checkOutput("t3Hold", outBus, 64'h0064_00C8_012C_0190);
         checkOutput("t3HoldValid", {63'd0, out_valid}, 64'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("t3StillHold", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("t3ReadyBack", {63'd0, in_ready}, 64'd1);
      checkOutput("t3Next", outBus, 64'h0005_0006_0007_0008);
      idle(2);

      // Misaligned short group is discarded with one error pulse
      errBase = seenErr;
      applyStimulus(16'd7, 1'b0);
      applyStimulus(16'd9, 1'b1);
      for (int i = 11; i <= 14; i++) applyStimulus(16'(i), i == 14);
      idle(3);
      checkOutput("t4ErrOnce", 64'(seenErr - errBase), 64'd1);
      checkOutput("t4Err", 64'(seenErr), 64'(expErr));

      // Missing in_last on the fourth word: group still emitted, error flagged
      errBase = seenErr;
      for (int i = 31; i <= 34; i++) applyStimulus(16'(i), 1'b0);
      for (int i = 61; i <= 64; i++) applyStimulus(16'(i), i == 64);
      idle(3);
      checkOutput("t4bErrOnce", 64'(seenErr - errBase), 64'd1);

      // Drain and completion on the same edge
      out_ready = 1'b0;
      for (int i = 41; i <= 44; i++) applyStimulus(16'(i), i == 44);
      for (int i = 51; i <= 53; i++) applyStimulus(16'(i), 1'b0);
      out_ready = 1'b1;
      applyStimulus(16'd54, 1'b1);
      checkOutput("t5NoStall", 64'(lastWait), 64'd0);
      @(negedge clk);
      checkOutput("t5Valid", {63'd0, out_valid}, 64'd1);
      idle(3);

      // Reset mid-group drops the partial words
      applyStimulus(16'd1, 1'b0);
      applyStimulus(16'd2, 1'b0);
      doReset(2);
      errBase = seenErr;
      for (int i = 21; i <= 24; i++) applyStimulus(16'(i), i == 24);
      idle(3);
      checkOutput("t6NoErr", 64'(seenErr - errBase), 64'd0);

`ifdef DEINTLV_ERR_CNT_EN
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      for (int g = 0; g < 3; g++) begin
         applyStimulus(16'(70 + g), 1'b0);
         applyStimulus(16'(80 + g), 1'b1);
      end
      idle(3);
      checkOutput("t7Count", 64'(err_count), 64'd3);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      @(negedge clk);
      checkOutput("t7Clear", 64'(err_count), 64'd0);
`endif

      w = 0;
      while (sb.size() != 0 && w < 50) begin
         @(posedge clk);
         w++;
      end
      checkOutput("sbEmpty", 64'(sb.size()), 64'd0);
      checkOutput("errTotal", 64'(seenErr), 64'(expErr));

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/channel_deinterleaver.md
Name: channel_deinterleaver

Overview:
Receive-side counterpart of the channel interleaver. It accepts a serial word stream carrying NUM_CHANNELS channel samples per pixel, in channel order 0..3, over a valid/ready handshake. It reassembles each group into parallel per-channel outputs with its own valid/ready handshake. It sits downstream of serialized links or DMA readers and feeds per-channel depthwise conv lanes. It also checks group alignment against an end-of-group marker.

Parameters:
DATA_WIDTH, 16, width of each channel sample
NUM_CHANNELS, 4, words per group; fixed at 4 because outputs are discrete ch0..ch3 ports
IDX_W, 2, width of word-index counter; must satisfy 2**IDX_W >= NUM_CHANNELS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  DATA_WIDTH  serial sample, channel order 0,1,2,3
in_valid  in  1  in_data valid
in_last  in  1  marks final word (channel 3) of a group; qualified by in_valid
in_ready  out  1  block can accept in_data this cycle
out_ch0  out  DATA_WIDTH  channel 0 of reassembled group
out_ch1  out  DATA_WIDTH  channel 1
out_ch2  out  DATA_WIDTH  channel 2
out_ch3  out  DATA_WIDTH  channel 3
out_valid  out  1  out_ch0..3 hold a complete group
out_ready  in  1  downstream accepts group
err_align  out  1  one-cycle pulse on alignment error

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low on rst_n. Every register clears immediately on rst_n low.
- Reset values:
  - idx = 0, state = COLLECT
  - out_valid = 0, out_ch0..3 = 0, err_align = 0
  - in_ready = 1 once in COLLECT. Upstream must hold in_valid low during reset.
- Handshakes: an input word transfers when in_valid & in_ready. A group transfers out when out_valid & out_ready.
- Output stability: out_ch0..3 are registered and remain stable while out_valid=1 and out_ready=0.
- Storage:
  - Assembly register asm[0..3].
  - Output register bank.
  - Index counter idx (0..NUM_CHANNELS-1).
- FSM state COLLECT: in_ready = 1. On each accepted word, asm[idx] <= in_data.
  - idx < NUM_CHANNELS-1: idx <= idx+1.
  - idx == NUM_CHANNELS-1 (group complete), output free (out_valid=0, or out_ready=1 this cycle): copy asm[0..2] plus in_data into the output bank, out_valid <= 1, idx <= 0. Stay in COLLECT.
  - idx == NUM_CHANNELS-1, output occupied and not draining: asm[3] <= in_data, idx <= 0, go to HOLD.
- FSM state HOLD: in_ready = 0.
  - When out_ready=1, the output bank loads from asm and out_valid stays 1. Go to COLLECT.
- Output drain with no new group: when out_valid & out_ready and no group completes that cycle, out_valid <= 0.
- Latency: first output cycle is one clk after the last word's handshake.
- Throughput: sustained 1 word/cycle with out_ready=1, i.e. one group per NUM_CHANNELS cycles, with no bubbles.
- Alignment check (evaluated only on an accepted word):
  - in_last=1 with idx != NUM_CHANNELS-1: err_align pulses the next cycle. The partial group and this word are discarded, and idx <= 0.
  - idx == NUM_CHANNELS-1 with in_last=0: the group is still emitted normally, and err_align pulses the next cycle.
- Boundaries:
  - Simultaneous drain and completion in COLLECT: the new group replaces the old one in the same edge, and out_valid stays 1.
  - in_valid low mid-group: idx holds and there is no timeout.
- Reset mid-operation: the partial group, held group and pending output are all dropped. The next accepted word is channel 0.
- Width rules: no arithmetic on data; samples are passed bit-exact.

Optional Feature:
- Macro: DEINTLV_ERR_CNT_EN.
- When defined:
  - Adds output port err_count (16 bits), reset to 0.
  - err_count increments on every err_align pulse and saturates at 16'hFFFF.
  - Adds input err_clr (1 bit): synchronous clear to 0. err_clr has priority over an increment in the same cycle.
- When undefined: the ports and the counter are absent, and err_align behaviour is unchanged.

Test Plan:
- Single group, out_ready=1: words 10, 20, 30, 40 with in_last on 40 -> one clk later out_valid=1 with ch0..3 = 10/20/30/40 for exactly one cycle; err_align stays 0.
- Back-to-back, continuous in_valid: words 1..8 with in_last on 4 and 8 -> in_ready stays 1; groups {1,2,3,4} and {5,6,7,8} appear 4 cycles apart.
- Backpressure:
  - Stimulus: group {100,200,300,400} completes, then out_ready=0 for 10 cycles while {5,6,7,8} is sent.
  - Response: outputs hold 100..400; in_ready drops one cycle after word 8 is accepted.
  - On out_ready=1: {5,6,7,8} presents the next cycle and in_ready returns to 1.
- Misalignment: words 7, 9 with in_last on 9, then clean group 11..14 -> err_align pulses once; the first output is {11,12,13,14}.
- Reset mid-group: words 1, 2 accepted, then rst_n low for 2 cycles, then group 21..24 -> out_valid=0 during reset; output is {21,22,23,24} with no error.
- With DEINTLV_ERR_CNT_EN: three misaligned groups -> err_count = 3; after err_clr pulse, err_count = 0.
